// File: rtl/mil_pkg.sv
// Shared types and constants for the MIL-STD-1553 transmit message sequencer.
package mil_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CW   = 2'd1,
    ST_WD   = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_UNDR = 2'b01;
  localparam logic [1:0] ERR_OVF  = 2'b10;
  localparam logic [1:0] ERR_WC   = 2'b11;

  localparam int MIL_WC_MAX = 32;
  localparam int MIL_WORD_W = 16;

  // Command-word count field: 0 encodes the maximum of 32 words.
  function automatic logic [5:0] word_count(input logic [4:0] field);
    return (field == 5'd0) ? 6'(MIL_WC_MAX) : {1'b0, field};
  endfunction

endpackage

// File: rtl/mil_wd_fifo.sv
// First-word-fall-through data-word FIFO with level output; flush and reset both empty it.
module mil_wd_fifo
  import mil_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    we,
  input  logic [MIL_WORD_W-1:0]   wdat,
  input  logic                    re,
  output logic [MIL_WORD_W-1:0]   rdat,
  output logic [$clog2(DEPTH):0]  lvl,
  output logic                    empty,
  output logic                    ovf
);
  localparam int AW = $clog2(DEPTH);

  logic [MIL_WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]         wp;
  logic [AW-1:0]         rp;
  logic                  full;
  logic                  do_rd;
  logic                  do_wr;

  assign empty = (lvl == '0);
  assign full  = (lvl == (AW+1)'(DEPTH));
  assign do_rd = re & ~empty & ~flush;
  // A pop in the same cycle frees the slot, so a write to a full FIFO is still taken.
  assign do_wr = we & ~flush & (~full | do_rd);
  assign ovf   = we & ~flush & full & ~do_rd;
  assign rdat  = mem[rp];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wp] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp  <= '0;
      rp  <= '0;
      lvl <= '0;
    end else begin
      if (do_wr) wp <= wp + 1'b1;
      if (do_rd) rp <= rp + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   lvl <= lvl + 1'b1;
        2'b01:   lvl <= lvl - 1'b1;
        default: lvl <= lvl;
      endcase
    end
  end

endmodule

// File: rtl/mil_tx_frame_ctrl.sv
// Sequences a command word plus queued data words into MIL_TXD, then enforces the inter-message gap.
// MIL_TXC_WC_CHECK_EN: use cw[4:0] as word count and refuse a start when the FIFO holds too few words.
module mil_tx_frame_ctrl
  import mil_pkg::*;
#(
  parameter int FIFO_DEPTH = 32,
  parameter int GAP_BITS   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_tact,
  input  logic        t_end,
  input  logic        wd_we,
  input  logic [15:0] wd_dat,
  input  logic        start,
  input  logic [15:0] cw,
  input  logic        abort,
  output logic [15:0] tx_dat,
  output logic        tx_en,
  output logic        tx_cw,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [5:0]  fifo_lvl
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  state_t                state;
  logic [5:0]            rem;
  logic [3:0]            gap_cnt;
  logic [MIL_WORD_W-1:0] head;
  logic [LW-1:0]         lvl;
  logic                  empty;
  logic                  ovf;
  logic [5:0]            wc_req;
  logic                  more;
  logic                  want;
  logic                  pop;
  logic                  undr;
  logic                  refuse;

  mil_wd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .we    (wd_we),
    .wdat  (wd_dat),
    .re    (pop),
    .rdat  (head),
    .lvl   (lvl),
    .empty (empty),
    .ovf   (ovf)
  );

  // The host-visible level is capped at the maximum message length.
  assign fifo_lvl = (lvl >= LW'(MIL_WC_MAX)) ? 6'(MIL_WC_MAX) : 6'(lvl);
  assign wc_req   = word_count(cw[4:0]);

`ifdef MIL_TXC_WC_CHECK_EN
  assign more   = (rem != 6'd0);
  assign undr   = want & empty;
  assign refuse = (fifo_lvl < wc_req);
`else
  // Without a word count the message simply ends when the FIFO runs dry after the first data word.
  assign more   = 1'b1;
  assign undr   = (state == ST_CW) & empty;
  assign refuse = 1'b0;
`endif

  assign want = (state == ST_CW) | ((state == ST_WD) & more);
  assign pop  = t_end & ~abort & want & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      rem     <= '0;
      gap_cnt <= '0;
      tx_dat  <= '0;
      tx_en   <= 1'b0;
      tx_cw   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= ERR_NONE;
    end else begin
      done <= 1'b0;
      if (ovf) err <= ERR_OVF;
      if (abort) begin
        state <= ST_IDLE;
        tx_en <= 1'b0;
        tx_cw <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              if (refuse) begin
                err <= ERR_WC;
              end else begin
                err    <= ovf ? ERR_OVF : ERR_NONE;
                tx_dat <= cw;
                tx_en  <= 1'b1;
                tx_cw  <= 1'b1;
                busy   <= 1'b1;
                rem    <= wc_req;
                state  <= ST_CW;
              end
            end
          end
          ST_CW, ST_WD: begin
            if (t_end) begin
              if (pop) begin
                tx_dat <= head;
                tx_cw  <= 1'b0;
                rem    <= rem - 1'b1;
                state  <= ST_WD;
              end else begin
                tx_en   <= 1'b0;
                tx_cw   <= 1'b0;
                gap_cnt <= '0;
                state   <= ST_GAP;
                if (undr) err <= ERR_UNDR;
              end
            end
          end
          ST_GAP: begin
            if (ce_tact) begin
              if (gap_cnt == 4'(GAP_BITS - 1)) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= (err == ERR_NONE) && !ovf;
              end else begin
                gap_cnt <= gap_cnt + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mil_tx_frame_ctrl.sv
// Directed bench for mil_tx_frame_ctrl: a per-cycle vector table for the nominal message plus corner-case sequences.
module tb_mil_tx_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce_tact = 1'b0;
  logic        t_end = 1'b0;
  logic        wd_we = 1'b0;
  logic [15:0] wd_dat = 16'h0;
  logic        start = 1'b0;
  logic [15:0] cw = 16'h0;
  logic        abort = 1'b0;
  logic [15:0] tx_dat;
  logic        tx_en;
  logic        tx_cw;
  logic        busy;
  logic        done;
  logic [1:0]  err;
  logic [5:0]  fifo_lvl;

  int checks = 0;
  int errors = 0;

  mil_tx_frame_ctrl #(.FIFO_DEPTH(32), .GAP_BITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce_tact  (ce_tact),
    .t_end    (t_end),
    .wd_we    (wd_we),
    .wd_dat   (wd_dat),
    .start    (start),
    .cw       (cw),
    .abort    (abort),
    .tx_dat   (tx_dat),
    .tx_en    (tx_en),
    .tx_cw    (tx_cw),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .fifo_lvl (fifo_lvl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] wdat;
    logic        st;
    logic [15:0] cwv;
    logic        te;
    logic        ce;
    logic [15:0] e_dat;
    logic        e_en;
    logic        e_cw;
    logic        e_busy;
    logic        e_done;
    logic [1:0]  e_err;
    logic [5:0]  e_lvl;
  } vec_t;

  vec_t vt [13];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_st(input string nm, input logic en, input logic b,
                        input logic [1:0] e, input logic [5:0] l);
    chk({nm, ".tx_en"}, 32'(tx_en), 32'(en));
    chk({nm, ".busy"}, 32'(busy), 32'(b));
    chk({nm, ".err"}, 32'(err), 32'(e));
    chk({nm, ".fifo_lvl"}, 32'(fifo_lvl), 32'(l));
  endtask

  task automatic chk_all(input string nm, input logic [15:0] d, input logic en, input logic c,
                         input logic b, input logic dn, input logic [1:0] e, input logic [5:0] l);
    chk({nm, ".tx_dat"}, 32'(tx_dat), 32'(d));
    chk({nm, ".tx_cw"}, 32'(tx_cw), 32'(c));
    chk({nm, ".done"}, 32'(done), 32'(dn));
    chk_st(nm, en, b, e, l);
  endtask

  task automatic wr(input logic [15:0] d);
    wd_we = 1'b1;
    wd_dat = d;
    cyc();
    wd_we = 1'b0;
  endtask

  task automatic go(input logic [15:0] c);
    start = 1'b1;
    cw = c;
    cyc();
    start = 1'b0;
  endtask

  task automatic tend();
    t_end = 1'b1;
    cyc();
    t_end = 1'b0;
  endtask

  // Four bit strobes with idle cycles between; done is due right after the fourth.
  task automatic gap(input string nm, input logic exp_done);
    for (int k = 0; k < 3; k++) begin
      ce_tact = 1'b1;
      cyc();
      ce_tact = 1'b0;
      cyc();
    end
    ce_tact = 1'b1;
    cyc();
    ce_tact = 1'b0;
    chk({nm, ".done"}, 32'(done), 32'(exp_done));
    chk({nm, ".busy"}, 32'(busy), 32'(1'b0));
    cyc();
    chk({nm, ".done_off"}, 32'(done), 32'(1'b0));
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < 13; i++) begin
      wd_we = vt[i].we;
      wd_dat = vt[i].wdat;
      start = vt[i].st;
      cw = vt[i].cwv;
      t_end = vt[i].te;
      ce_tact = vt[i].ce;
      cyc();
      chk_all($sformatf("%s[%0d]", nm, i), vt[i].e_dat, vt[i].e_en, vt[i].e_cw,
              vt[i].e_busy, vt[i].e_done, vt[i].e_err, vt[i].e_lvl);
    end
    wd_we = 1'b0;
    start = 1'b0;
    t_end = 1'b0;
    ce_tact = 1'b0;
  endtask

  initial begin
    logic seen_done;

    //           we    wdat     st    cw       te    ce    dat      en    cw    busy  done  err    lvl
    vt[0]  = '{1'b1, 16'h2D0F, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 6'd1};
    vt[1]  = '{1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 6'd2};
    vt[2]  = '{1'b0, 16'h0000, 1'b1, 16'h6682, 1'b0, 1'b0, 16'h6682, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 6'd2};
    vt[3]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h6682, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 6'd2};
    vt[4]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h2D0F, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 6'd1};
    vt[5]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 6'd0};
    vt[6]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 6'd0};
    vt[7]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 6'd0};
    vt[8]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 6'd0};
    vt[9]  = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 6'd0};
    vt[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 6'd0};
    vt[11] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 6'd0};
    vt[12] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 6'd0};

    // Reset
    repeat (3) cyc();
    rst = 1'b0;
    chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 6'd0);

    run_table("nom1");

    // Overflow: 33rd write is dropped, then a 32-word message drains exactly the 32 kept words
    for (int i = 0; i < 32; i++) wr(16'h0100 + 16'(i));
    chk_st("fill32", 1'b0, 1'b0, 2'b00, 6'd32);
    wr(16'h0120);
    chk_st("ovf", 1'b0, 1'b0, 2'b10, 6'd32);
    go(16'h6680);
    chk_all("ovf_start", 16'h6680, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 6'd32);
    for (int i = 0; i < 32; i++) begin
      tend();
      chk_all($sformatf("ovf_wd%0d", i), 16'h0100 + 16'(i), 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 6'(31 - i));
    end
    tend();
    chk_all("ovf_last", 16'h011F, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 6'd0);
    gap("ovf_gap", 1'b1);

    // Start with an empty FIFO
    go(16'h6680);
`ifdef MIL_TXC_WC_CHECK_EN
    chk_st("wc32_empty", 1'b0, 1'b0, 2'b11, 6'd0);
`else
    chk_all("undr_cw", 16'h6680, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 6'd0);
    tend();
    chk_st("undr", 1'b0, 1'b1, 2'b01, 6'd0);
    gap("undr_gap", 1'b0);
    chk_st("undr_end", 1'b0, 1'b0, 2'b01, 6'd0);
`endif

    // Word-count mismatch: one word queued, cw asks for 25
    wr(16'hCAFE);
    go(16'h6699);
`ifdef MIL_TXC_WC_CHECK_EN
    chk_st("wc_mis", 1'b0, 1'b0, 2'b11, 6'd1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_st("wc_flush", 1'b0, 1'b0, 2'b11, 6'd0);
`else
    chk_all("wcm_cw", 16'h6699, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 6'd1);
    tend();
    chk_all("wcm_wd", 16'hCAFE, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 6'd0);
    tend();
    chk_st("wcm_end", 1'b0, 1'b1, 2'b00, 6'd0);
    gap("wcm_gap", 1'b1);
`endif

    // Abort mid data word; also a start while busy must be ignored
    wr(16'h00A1);
    wr(16'h00A2);
    wr(16'h00A3);
    go(16'h6683);
    chk_all("ab_cw", 16'h6683, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 6'd3);
    go(16'hBEEF);
    chk_all("busy_start", 16'h6683, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 6'd3);
    tend();
    chk_all("ab_wd", 16'h00A1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 6'd2);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk_all("abort", 16'h00A1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 6'd0);
    seen_done = 1'b0;
    for (int k = 0; k < 5; k++) begin
      ce_tact = 1'b1;
      cyc();
      ce_tact = 1'b0;
      if (done) seen_done = 1'b1;
      cyc();
      if (done) seen_done = 1'b1;
    end
    chk("ab_nodone", 32'(seen_done), 32'(1'b0));
    chk_st("ab_idle", 1'b0, 1'b0, 2'b00, 6'd0);

    // Abort and start in the same cycle
    wr(16'h0055);
    abort = 1'b1;
    go(16'h6681);
    abort = 1'b0;
    chk_all("ab_start", 16'h00A1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 6'd0);
    cyc();
    chk_st("ab_start2", 1'b0, 1'b0, 2'b00, 6'd0);

    // Reset during a data word, then a clean nominal message
    wr(16'h1111);
    wr(16'h2222);
    go(16'h6682);
    tend();
    chk_all("pre_rst", 16'h1111, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 6'd1);
    rst = 1'b1;
    cyc();
    chk_all("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 6'd0);
    rst = 1'b0;
    cyc();
    run_table("nom2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
